// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit combinational full subtractor: d = x - y - bi, borrow out on bo.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;

  full_sub_cell u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // The borrow flop doubles as the registered borrow-out.
  assign bout = brw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          diff <= {d, diff[WIDTH-1:1]};
          brw  <= bo;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Sign bits of a and b differ and the result sign differs from a.
            ovf   <= (a_sr[0] ^ b_sr[0]) & (a_sr[0] ^ d);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a result scoreboard.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                                 input logic ibin);
    exp_t           e;
    logic [WIDTH:0] full;
    full   = {1'b0, ia} - {1'b0, ib} - {{WIDTH{1'b0}}, ibin};
    e.diff = full[WIDTH-1:0];
    e.bout = full[WIDTH];
    e.ovf  = (ia[WIDTH-1] ^ ib[WIDTH-1]) & (ia[WIDTH-1] ^ full[WIDTH-1]);
    return e;
  endfunction

  // Waits on negedges until done rises or the budget expires; returns cycles waited.
  task automatic wait_done(input string tag, output int waited, output int busy_cycles);
    waited      = 0;
    busy_cycles = 0;
    while (!done && waited < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      waited++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_diff"}, diff, e.diff);
      check({tag, "_bout"}, bout, e.bout);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, ovf, e.ovf);
`endif
      $display("op %s: diff=0x%02h bout=%0b (expected 0x%02h/%0b)", tag, diff, bout, e.diff, e.bout);
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                        input logic ibin);
    int waited;
    int busy_cycles;
    @(negedge clk);
    a     = ia;
    b     = ib;
    bin   = ibin;
    start = 1'b1;
    sb.push_back(model(ia, ib, ibin));
    @(negedge clk);
    start = 1'b0;
    wait_done(tag, waited, busy_cycles);
    // waited counts from the negedge after the start edge, so it equals edges to done.
    check({tag, "_latency"}, waited + 1, WIDTH + 1);
    check({tag, "_busy_cycles"}, busy_cycles, WIDTH);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    compare_result(tag);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    check({tag, "_diff_hold"}, diff, model(ia, ib, ibin).diff);
    check({tag, "_bout_hold"}, bout, model(ia, ib, ibin).bout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    int   busy_cycles;
    int   quiet;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_diff", diff, '0);
    check("reset_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;

    run_op("sub_35_12", 8'h35, 8'h12, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b0);
    run_op("sub_10_10_bin1", 8'h10, 8'h10, 1'b1);
    run_op("sub_10_10_bin0", 8'h10, 8'h10, 1'b0);
    run_op("sub_ff_00_bin1", 8'hFF, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom_range(0, 1)));
    end
`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_80_01", 8'h80, 8'h01, 1'b0);
    run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0);
`endif

    // Start held high: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    a     = 8'h05;
    b     = 8'h03;
    bin   = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(8'h05, 8'h03, 1'b0));
    @(negedge clk);
    wait_done("hold0", waited, busy_cycles);
    check("hold0_latency", waited + 1, WIDTH + 1);
    compare_result("hold0");
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      wait_done($sformatf("hold%0d", i), waited, busy_cycles);
      check($sformatf("hold%0d_interval", i), waited + 1, WIDTH + 2);
      compare_result($sformatf("hold%0d", i));
    end
    start = 1'b0;
    quiet = 1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (done || busy) quiet = 0;
    end
    check("hold_stops_when_start_low", quiet, 1);
    check("hold_sb_drained", sb.size(), 0);

    // Reset in the middle of an operation that already has a borrow and partial diff.
    @(negedge clk);
    a     = 8'h00;
    b     = 8'h01;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("midshift_busy", busy, 1'b1);
    check("midshift_borrow_set", bout, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_done", done, 1'b0);
    check("async_rst_diff", diff, '0);
    check("async_rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("async_rst_ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst   = 1'b0;
    quiet = 1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      if (done || busy) quiet = 0;
    end
    check("rst_discards_inflight", quiet, 1);
    run_op("after_rst_09_04", 8'h09, 8'h04, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
